// File: rtl/ps2_kbd_event_rx.sv
// PS/2 keyboard receiver: deframes device-to-host frames, decodes E0/F0 prefixes into key
// events and queues them in a FWFT FIFO. Define PS2_TYPEMATIC_FILTER_EN to drop typematic repeats.
module ps2_kbd_event_rx #(
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       PS2_CLK,
    input  logic       PS2_DATA,
    input  logic       RD_EN,
    input  logic       CLR_ERR,
    output logic [9:0] EVT_DATA,
    output logic       EVT_VALID,
    output logic       FIFO_FULL,
    output logic       OVERFLOW,
    output logic       FRAME_ERR,
    output logic [7:0] LED
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} frame_state_t;

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] data_sync;
    logic                   clk_prev;
    logic                   ps2_clk_s;
    logic                   ps2_data_s;
    logic                   fall;

    // Sync flops reset to the idle-high line level so reset release never looks like an edge.
    // NOTE: sequential state always uses <=, so every flop samples pre-edge values regardless of block order.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            clk_sync  <= '1;
            data_sync <= '1;
            clk_prev  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], PS2_CLK};
            data_sync <= {data_sync[SYNC_STAGES-2:0], PS2_DATA};
            clk_prev  <= ps2_clk_s;
        end
    end

    assign ps2_clk_s  = clk_sync[SYNC_STAGES-1];
    assign ps2_data_s = data_sync[SYNC_STAGES-1];
    assign fall       = clk_prev & ~ps2_clk_s;

    frame_state_t    state, state_next;
    logic [2:0]      bit_cnt;
    logic [7:0]      shift_reg;
    logic            parity_bit;
    logic [TW-1:0]   timer;
    logic            timeout;
    logic            frame_done;
    logic            frame_ok;
    logic            frame_err_set;
    logic            byte_valid;

    assign timeout       = (state != S_IDLE) && !fall && (timer == TW'(TIMEOUT_CYCLES - 1));
    assign frame_done    = (state == S_STOP) && fall;
    assign frame_ok      = frame_done && ps2_data_s && (^{shift_reg, parity_bit});
    assign frame_err_set = (frame_done && !frame_ok) || timeout;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state <= S_IDLE;
        else      state <= state_next;
    end

    // NOTE: state_next gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (fall && !ps2_data_s) state_next = S_DATA;
            S_DATA:   if (fall && bit_cnt == 3'd7) state_next = S_PARITY;
            S_PARITY: if (fall) state_next = S_STOP;
            S_STOP:   if (fall) state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
        if (timeout) state_next = S_IDLE;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            bit_cnt    <= '0;
            shift_reg  <= '0;
            parity_bit <= 1'b0;
            timer      <= '0;
            byte_valid <= 1'b0;
        end else begin
            timer      <= (state == S_IDLE || fall) ? '0 : timer + 1'b1;
            byte_valid <= frame_ok;
            if (fall) begin
                case (state)
                    S_IDLE:   bit_cnt <= '0;
                    S_DATA: begin
                        shift_reg <= {ps2_data_s, shift_reg[7:1]};
                        bit_cnt   <= bit_cnt + 1'b1;
                    end
                    S_PARITY: parity_bit <= ps2_data_s;
                    default:  ;
                endcase
            end
        end
    end

    // Decoder: shift_reg is stable in the cycle after the stop bit, so it is the received byte.
    logic       ext_flag;
    logic       brk_flag;
    logic       ev_push;
    logic [9:0] ev_data;

`ifdef PS2_TYPEMATIC_FILTER_EN
    logic [8:0] held_key;
    logic       held_valid;
    logic       key_match;

    assign key_match = held_valid && (held_key == {ext_flag, shift_reg});
`endif

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ext_flag   <= 1'b0;
            brk_flag   <= 1'b0;
            ev_push    <= 1'b0;
            ev_data    <= '0;
`ifdef PS2_TYPEMATIC_FILTER_EN
            held_key   <= '0;
            held_valid <= 1'b0;
`endif
        end else begin
            ev_push <= 1'b0;
            if (byte_valid) begin
                if (shift_reg == 8'hE0) begin
                    ext_flag <= 1'b1;
                end else if (shift_reg == 8'hF0) begin
                    brk_flag <= 1'b1;
                end else begin
                    ext_flag <= 1'b0;
                    brk_flag <= 1'b0;
                    ev_data  <= {ext_flag, brk_flag, shift_reg};
`ifdef PS2_TYPEMATIC_FILTER_EN
                    if (!brk_flag) begin
                        ev_push <= !key_match;
                        if (!key_match) begin
                            held_key   <= {ext_flag, shift_reg};
                            held_valid <= 1'b1;
                        end
                    end else begin
                        ev_push <= 1'b1;
                        if (key_match) held_valid <= 1'b0;
                    end
`else
                    ev_push  <= 1'b1;
`endif
                end
            end
        end
    end

    // FWFT FIFO; the extra pointer bit separates full from empty.
    logic [9:0]  mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        empty;
    logic        full;
    logic        do_rd;
    logic        do_wr;
    logic        ovf_set;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_rd   = RD_EN && !empty;
    assign do_wr   = ev_push && (!full || do_rd);
    assign ovf_set = ev_push && full && !do_rd;

    // NOTE: storage has no reset; entries are only visible through EVT_DATA while non-empty.
    always_ff @(posedge CLK) begin
        if (do_wr) mem[wr_ptr[AW-1:0]] <= ev_data;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            LED       <= '0;
            OVERFLOW  <= 1'b0;
            FRAME_ERR <= 1'b0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            if (ev_push && !ev_data[8]) LED <= ev_data[7:0];
            OVERFLOW  <= ovf_set | (OVERFLOW & ~CLR_ERR);
            FRAME_ERR <= frame_err_set | (FRAME_ERR & ~CLR_ERR);
        end
    end

    assign EVT_VALID = !empty;
    assign FIFO_FULL = full;
    assign EVT_DATA  = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: doc/ps2_kbd_event_rx.md
Name: ps2_kbd_event_rx

Overview:
- Parametrised PS/2 keyboard receiver; successor to the single-register keyboard-to-LED block.
- Deframes PS/2 device-to-host frames and checks start, parity and stop bits.
- Decodes E0/F0 prefixes into key events and buffers the events in a first-word-fall-through FIFO for the game/scene logic.
- Keeps the LED debug output (last make code) for board bring-up.

Parameters:
- FIFO_DEPTH, 8, event FIFO entries; power of 2, minimum 2.
- TIMEOUT_CYCLES, 50000, CLK cycles without a PS2_CLK falling edge before a partial frame is aborted (1 ms at 50 MHz).
- SYNC_STAGES, 2, synchroniser flops on PS2_CLK and PS2_DATA; minimum 2.

Ports:
- CLK  in  1  system clock.
- RST  in  1  asynchronous, active-low reset.
- PS2_CLK  in  1  raw keyboard clock (asynchronous).
- PS2_DATA  in  1  raw keyboard data (asynchronous).
- RD_EN  in  1  pop the FIFO head when EVT_VALID=1.
- CLR_ERR  in  1  synchronous clear of the sticky error flags.
- EVT_DATA  out  10  FIFO head {ext, brk, code[7:0]}; valid only while EVT_VALID=1.
- EVT_VALID  out  1  FIFO not empty.
- FIFO_FULL  out  1  FIFO holds FIFO_DEPTH entries.
- OVERFLOW  out  1  sticky: an event was dropped because the FIFO was full.
- FRAME_ERR  out  1  sticky: bad stop bit, bad parity, or timeout.
- LED  out  8  code byte of the most recent make (brk=0) event.

Behaviour:
- Reset (RST=0, asynchronous): all outputs 0, FIFO empty, pointers 0, FSMs in IDLE, prefix flags cleared. Release is synchronous to CLK.
- Sampling:
  - Both inputs pass through SYNC_STAGES flops.
  - A falling edge is a registered-previous=1 and current=0 on synchronised PS2_CLK.
  - Data is sampled only on a falling edge.
- Frame FSM:
  - IDLE: on a falling edge with data=0 (start bit), go to DATA with bit count 0. Data=1 at the edge is ignored; stay in IDLE.
  - DATA: shift 8 bits, LSB first, then go to PARITY.
  - PARITY: capture the parity bit, go to STOP.
  - STOP: on a falling edge, if stop=1 and odd parity over data+parity holds, pulse byte_valid for 1 cycle. Otherwise set FRAME_ERR and discard the byte. Return to IDLE either way.
  - Timeout: in any non-IDLE state, a cycle counter resets on each falling edge. When it reaches TIMEOUT_CYCLES: go to IDLE, set FRAME_ERR, discard the partial byte.
- Decoder:
  - Byte 0xE0 sets ext; 0xF0 sets brk. Neither emits an event.
  - Any other byte emits the event {ext, brk, byte} and clears ext and brk in the same cycle.
  - Sequence E0 F0 xx emits ext=1, brk=1.
  - Prefix flags persist across a frame error; they clear only on reset or when an event is emitted.
- FIFO (FWFT):
  - Write on event when not full. When full, the event is dropped and OVERFLOW is set.
  - Read when RD_EN=1 and EVT_VALID=1. RD_EN while empty is ignored with no pointer movement.
  - Simultaneous read and write while full: both performed, no overflow, FIFO_FULL stays 1.
  - Simultaneous read and write with one entry: EVT_VALID stays 1 and the new entry appears next cycle.
  - Pointers wrap modulo FIFO_DEPTH. Full/empty are resolved with an extra pointer bit or an occupancy counter of width clog2(FIFO_DEPTH)+1.
- Latency: EVT_VALID (from empty) rises exactly SYNC_STAGES+3 CLK edges after the first edge at which raw PS2_CLK is sampled low for the stop bit.
- LED: updates on the same cycle the make event is written to the FIFO, or would have been written if the FIFO were full. Break events do not change LED.
- Error flags:
  - CLR_ERR clears OVERFLOW and FRAME_ERR next cycle.
  - A set condition in the same cycle as CLR_ERR wins (the flag stays 1).
- Reset mid-frame: the partial frame and the FIFO contents are lost; no error is flagged.

Optional Feature:
- Macro: PS2_TYPEMATIC_FILTER_EN.
- When defined:
  - The block holds a "held key" register {ext, code} and a held-valid bit.
  - A make event matching the held key while held-valid=1 is suppressed: not written to the FIFO, and LED is unchanged.
  - A break event matching the held key clears held-valid and is written normally.
  - Any other make event replaces the held key.
- When undefined: every typematic repeat is written as a separate make event.

Test Plan:
- Frame 0x1C (start 0, data, parity 0, stop 1) -> EVT_DATA=0x01C, EVT_VALID high after SYNC_STAGES+3 cycles, LED=0x1C.
- Sequence E0 F0 75 -> a single event 0x375; LED unchanged from its prior value.
- Frame 0x1C with parity bit flipped -> no event, FRAME_ERR=1; CLR_ERR pulse -> FRAME_ERR=0. PS2_CLK stopped after 4 data bits for TIMEOUT_CYCLES -> FRAME_ERR=1; the next valid frame 0x32 decodes to 0x032.
- FIFO_DEPTH+1 make frames with no reads -> FIFO_FULL=1, OVERFLOW=1, the first FIFO_DEPTH codes read back in order. Then RD_EN held high until empty -> EVT_VALID=0; extra RD_EN causes no pointer change.
- Full FIFO with RD_EN=1 in the exact cycle a new event arrives -> FIFO_FULL stays 1, OVERFLOW stays 0, order preserved. RST asserted mid-frame -> all outputs 0 immediately.
- With PS2_TYPEMATIC_FILTER_EN: 1C 1C 1C F0 1C 1C -> events 0x01C, 0x11C, 0x01C only. Without the macro: five events.
